risc_v_mike_load_store_unit: RTL

- Sits between the core execute stage and the word-addressed data memory.
- Translates RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into whole-word memory accesses.
- Byte and half stores use a two-cycle read-modify-write, because the memory has no byte enables.
- Returns sign- or zero-extended load data one cycle after acceptance; flags misaligned and out-of-range accesses.

---
 rtl/risc_v_mike_load_store_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/risc_v_mike_load_store_unit.sv
// RV32I load/store unit: maps byte/half/word loads and stores onto a
// word-only data memory, using read-modify-write for sub-word stores.
module risc_v_mike_load_store_unit #(
  parameter int DATA_MEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_write,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wr_data,
  output logic        lsu_rd_valid,
  output logic [31:0] lsu_rd_data,
  output logic        lsu_err,
  output logic [31:0] data_mem_addr,
  output logic        data_mem_write,
  output logic [31:0] data_mem_wr_data,
  input  logic [31:0] data_mem_rd_data
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(DATA_MEM_DEPTH);

  state_t      state_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_old_q;
  logic [15:0] cap_wdata_q;
  logic [2:0]  cap_f3_q;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic        err_q;

  logic        accept;
  logic        mis_align;
  logic        bad_f3;
  logic        out_range;
  logic        op_err;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Pick the addressed byte/half out of a memory word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Replace one byte lane (SB) or half lane (SH) of the old word.
  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3,
                                              input logic [15:0] wdata);
    logic [31:0] m;
    m = old;
    if (f3 == 3'b000) m[{off, 3'b000} +: 8] = wdata[7:0];
    else              m[{off[1], 4'b0000} +: 16] = wdata;
    return m;
  endfunction

  assign lsu_req_ready = (state_q == IDLE);
  assign accept        = lsu_req_valid && lsu_req_ready;
  assign lsu_rd_valid  = rd_valid_q;
  assign lsu_rd_data   = rd_data_q;
  assign lsu_err       = err_q;

  // Decode legality of the presented op and build the memory-side signals.
  always_comb begin
    mis_align = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
    bad_f3    = lsu_req_write ? (lsu_funct3 > 3'b010)
                              : ((lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11));
    out_range = (lsu_addr[31:2] >= WORD_LIMIT);
    op_err    = mis_align || bad_f3 || out_range;
    load_val  = load_extend(data_mem_rd_data, lsu_addr[1:0], lsu_funct3);
    merged    = merge_store(cap_old_q, cap_addr_q[1:0], cap_f3_q, cap_wdata_q);

    data_mem_addr    = {lsu_addr[31:2], 2'b00};
    data_mem_wr_data = lsu_wr_data;
    data_mem_write   = 1'b0;
    if (state_q == RMW_WR) begin
      data_mem_addr    = {cap_addr_q[31:2], 2'b00};
      data_mem_wr_data = merged;
      data_mem_write   = rst;
    end else if (accept && !op_err && lsu_req_write && (lsu_funct3 == 3'b010)) begin
      data_mem_write   = rst;
    end
  end

  // FSM, sub-word store capture and registered load/error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cap_addr_q  <= '0;
      cap_old_q   <= '0;
      cap_wdata_q <= '0;
      cap_f3_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_err) begin
              err_q <= 1'b1;
            end else if (!lsu_req_write) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= load_val;
            end else if (lsu_funct3 != 3'b010) begin
              cap_addr_q  <= lsu_addr;
              cap_old_q   <= data_mem_rd_data;
              cap_wdata_q <= lsu_wr_data[15:0];
              cap_f3_q    <= lsu_funct3;
              state_q     <= RMW_WR;
            end
          end
        end
        RMW_WR: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
